// File: rtl/tcnt_timer_pkg.sv
// Shared types for the delay timer: request unit encoding, FSM states, unit-length helper.
// Combinational helpers only; no state and no flow control.
// Imported by the prescaler and the timer top.
package tcnt_timer_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        UNIT_CYCLE = 2'd0,
        UNIT_US    = 2'd1,
        UNIT_MS    = 2'd2,
        UNIT_RSVD  = 2'd3
    } unit_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_e;

    // Prescaler reload value (unit length minus one). The ms length can reach
    // 4e9, so it is formed in 64 bits before narrowing.
    function automatic logic [CNT_W-1:0] unit_period_m1(input unit_e unit,
                                                        input int unsigned cycles_per_us);
        logic [63:0]      ms_cyc;
        logic [CNT_W-1:0] result;
        ms_cyc = 64'(cycles_per_us) * 64'd1000;
        result = '0;
        case (unit)
            UNIT_CYCLE: result = '0;
            UNIT_US:    result = CNT_W'(cycles_per_us - 32'd1);
            UNIT_MS:    result = CNT_W'(ms_cyc - 64'd1);
            default:    result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/tcnt_prescaler.sv
// Reloadable down-counter producing one tick every (load_val+1) enabled cycles.
// Latency: first tick load_val+1 enabled cycles after load; tick is combinational from state.
// Backpressure: none; clear has priority over load, load over counting.
module tcnt_prescaler
    import tcnt_timer_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tick
);

    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == '0);

    always_comb begin
        reload_d = reload_q;
        cnt_d    = cnt_q;
        if (clear) begin
            reload_d = '0;
            cnt_d    = '0;
        end else if (load) begin
            reload_d = load_val;
            cnt_d    = load_val;
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_d = reload_q;
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
            cnt_q    <= '0;
        end else begin
            reload_q <= reload_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/tcnt_delay_timer.sv
// Delay timer: waits req_count cycles/us/ms after acceptance, then pulses done (or aborted).
// Latency: done pulse max(req_count*U,1) cycles after the accepting edge; reserved unit aborts next cycle.
// Backpressure: req_ready only in IDLE, so consecutive requests are separated by an IDLE cycle.
module tcnt_delay_timer
    import tcnt_timer_pkg::*;
#(
    parameter int unsigned CYCLES_PER_US = 1000,
    parameter int unsigned TS_W          = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_unit,
    input  logic [31:0]     req_count,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic [TS_W-1:0] timestamp,
    output logic [TS_W-1:0] done_stamp
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] unit_cnt_q, unit_cnt_d;
    logic [TS_W-1:0]  timestamp_q, timestamp_d;
    logic [TS_W-1:0]  done_stamp_q, done_stamp_d;

    logic             presc_clear;
    logic             presc_load;
    logic [CNT_W-1:0] presc_load_val;
    logic             presc_en;
    logic             presc_tick;
    unit_e            req_unit_e;

    assign req_unit_e = unit_e'(req_unit);

    tcnt_prescaler #(
        .WIDTH (CNT_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (presc_clear),
        .load     (presc_load),
        .load_val (presc_load_val),
        .en       (presc_en),
        .tick     (presc_tick)
    );

    assign timestamp_d = timestamp_q + TS_W'(1);

    always_comb begin
        state_d        = state_q;
        unit_cnt_d     = unit_cnt_q;
        done_stamp_d   = done_stamp_q;
        presc_clear    = 1'b0;
        presc_load     = 1'b0;
        presc_load_val = '0;
        presc_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_unit_e == UNIT_RSVD) begin
                        state_d = ST_ABORT;
                    end else begin
                        state_d    = ST_COUNT;
                        presc_load = 1'b1;
                        // A zero count still takes one cycle: run a single one-cycle unit.
                        if (req_count == 32'd0) begin
                            unit_cnt_d     = CNT_W'(1);
                            presc_load_val = '0;
                        end else begin
                            unit_cnt_d     = req_count;
                            presc_load_val = unit_period_m1(req_unit_e, CYCLES_PER_US);
                        end
                    end
                end
            end

            ST_COUNT: begin
                presc_en = 1'b1;
                // Cancel takes precedence even on the terminal-count edge.
                if (cancel) begin
                    state_d     = ST_ABORT;
                    unit_cnt_d  = '0;
                    presc_clear = 1'b1;
                end else if (presc_tick) begin
                    if (unit_cnt_q == CNT_W'(1)) begin
                        state_d      = ST_DONE;
                        unit_cnt_d   = '0;
                        presc_clear  = 1'b1;
                        done_stamp_d = timestamp_q;
                    end else begin
                        unit_cnt_d = unit_cnt_q - CNT_W'(1);
                    end
                end
            end

            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            unit_cnt_q   <= '0;
            timestamp_q  <= '0;
            done_stamp_q <= '0;
        end else begin
            state_q      <= state_d;
            unit_cnt_q   <= unit_cnt_d;
            timestamp_q  <= timestamp_d;
            done_stamp_q <= done_stamp_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_COUNT);
    assign done       = (state_q == ST_DONE);
    assign aborted    = (state_q == ST_ABORT);
    assign timestamp  = timestamp_q;
    assign done_stamp = done_stamp_q;

endmodule
